// File: rtl/acondicionador_temp_pkg.sv
// Shared types and limits for the temperature monitoring chain.
// Holds the 11-bit signed temperature type, its limits and the conditioner FSM states.
package pkg_monitoreo;

    typedef logic signed [10:0] temp_t;

    localparam temp_t TEMP_MIN = temp_t'(-1024);
    localparam temp_t TEMP_MAX = temp_t'(1023);

    typedef enum logic [1:0] {
        VACIO,
        LLENANDO,
        OPERANDO,
        FALLA
    } estado_acond_t;

    function automatic temp_t saturar(input logic signed [12:0] v);
        if (v > 13'(TEMP_MAX)) begin
            return TEMP_MAX;
        end else if (v < 13'(TEMP_MIN)) begin
            return TEMP_MIN;
        end
        return v[10:0];
    endfunction

endpackage

// File: rtl/acondicionador_temp_promedio.sv
// Moving average over 2**LOG2_N samples: circular buffer, running sum and write pointer.
// promedio and lleno already reflect the write presented on this cycle.
module promedio_movil
    import pkg_monitoreo::*;
#(
    parameter int LOG2_N = 2
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  wr_en,
    input  temp_t dato,
    output temp_t promedio,
    output logic  lleno
);

    localparam int N  = 1 << LOG2_N;
    localparam int SW = 11 + LOG2_N;
    localparam int PW = (LOG2_N > 0) ? LOG2_N : 1;
    localparam int CW = LOG2_N + 1;

    temp_t                mem_q [N];
    temp_t                mem_d [N];
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic signed [SW-1:0] sum_q, sum_d;

    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        sum_d = sum_q;
        if (wr_en) begin
            mem_d[ptr_q] = dato;
            // The sum holds at most N values of 11 bits, so SW bits cannot overflow.
            sum_d = sum_q + SW'(dato) - SW'(mem_q[ptr_q]);
            ptr_d = (ptr_q == PW'(N - 1)) ? '0 : ptr_q + 1'b1;
            if (cnt_q != CW'(N)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        promedio = temp_t'(sum_d >>> LOG2_N);
        lleno    = (cnt_d == CW'(N));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                mem_q[i] <= '0;
            end
            ptr_q <= '0;
            cnt_q <= '0;
            sum_q <= '0;
        end else begin
            mem_q <= mem_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            sum_q <= sum_d;
        end
    end

endmodule

// File: rtl/acondicionador_temp.sv
// Sensor conditioner: raw code -> clamped tenths of C -> moving average, with sticky fault.
// Two-stage pipeline: stage1 converts and flags, stage2 updates window, FSM and outputs.
module acondicionador_temp
    import pkg_monitoreo::*;
#(
    parameter int LOG2_N      = 2,
    parameter int OFFSET      = 400,
    parameter int MAX_ERR     = 3,
    parameter int TEMP_NEUTRA = 220
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        muestra_valida,
    input  logic [11:0] muestra_raw,
    output temp_t       temp_entrada,
    output logic        temp_valida,
    output logic        listo,
    output logic        falla_sensor
);

    localparam logic [3:0] MAX_ERR_C     = 4'(MAX_ERR);
    localparam temp_t      TEMP_NEUTRA_C = temp_t'(TEMP_NEUTRA);

    logic               s1_valid_q, s1_valid_d;
    logic               s1_err_q, s1_err_d;
    temp_t              s1_dato_q, s1_dato_d;
    logic signed [12:0] conv;

    estado_acond_t      estado_q, estado_d;
    logic [3:0]         err_cnt_q, err_cnt_d, err_inc;
    temp_t              temp_q, temp_d;
    logic               valida_q, valida_d;
    logic               listo_q, listo_d;
    logic               falla_q, falla_d;

    logic               wr_en;
    temp_t              promedio;
    logic               lleno;

    always_comb begin
        conv       = $signed({1'b0, muestra_raw}) - 13'(OFFSET);
        s1_valid_d = muestra_valida;
        s1_err_d   = (muestra_raw == 12'h000) || (muestra_raw == 12'hFFF);
        s1_dato_d  = saturar(conv);
    end

    // Once in FALLA the window is frozen, so no write reaches the buffer.
    assign wr_en   = s1_valid_q && !s1_err_q && (estado_q != FALLA);
    assign err_inc = (err_cnt_q >= MAX_ERR_C) ? err_cnt_q : err_cnt_q + 4'd1;

    promedio_movil #(
        .LOG2_N (LOG2_N)
    ) u_promedio (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .dato     (s1_dato_q),
        .promedio (promedio),
        .lleno    (lleno)
    );

    always_comb begin
        estado_d  = estado_q;
        err_cnt_d = err_cnt_q;
        temp_d    = temp_q;
        valida_d  = 1'b0;
        listo_d   = listo_q;
        falla_d   = falla_q;
        if (s1_valid_q && (estado_q != FALLA)) begin
            if (s1_err_q) begin
                err_cnt_d = err_inc;
                if (err_inc == MAX_ERR_C) begin
                    estado_d = FALLA;
                    falla_d  = 1'b1;
                end
            end else begin
                err_cnt_d = '0;
                case (estado_q)
                    VACIO, LLENANDO: begin
                        if (lleno) begin
                            estado_d = OPERANDO;
                            listo_d  = 1'b1;
                            temp_d   = promedio;
                            valida_d = 1'b1;
                        end else begin
                            estado_d = LLENANDO;
                        end
                    end
                    OPERANDO: begin
                        temp_d   = promedio;
                        valida_d = 1'b1;
                    end
                    default: begin
                        estado_d = estado_q;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_err_q   <= 1'b0;
            s1_dato_q  <= '0;
            estado_q   <= VACIO;
            err_cnt_q  <= '0;
            temp_q     <= TEMP_NEUTRA_C;
            valida_q   <= 1'b0;
            listo_q    <= 1'b0;
            falla_q    <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_err_q   <= s1_err_d;
            s1_dato_q  <= s1_dato_d;
            estado_q   <= estado_d;
            err_cnt_q  <= err_cnt_d;
            temp_q     <= temp_d;
            valida_q   <= valida_d;
            listo_q    <= listo_d;
            falla_q    <= falla_d;
        end
    end

    assign temp_entrada = temp_q;
    assign temp_valida  = valida_q;
    assign listo        = listo_q;
    assign falla_sensor = falla_q;

endmodule

// File: tb/tb_acondicionador_temp.sv
// Bench for acondicionador_temp: table of samples with settled expectations, plus a
// window model that predicts every temp_valida pulse (value and cycle) into a queue.
module tb_acondicionador_temp;
    import pkg_monitoreo::*;

    localparam int MAX_ERR = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        muestra_valida = 1'b0;
    logic [11:0] muestra_raw = '0;
    temp_t       temp_entrada;
    logic        temp_valida;
    logic        listo;
    logic        falla_sensor;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [26:0] exp_q[$];
    logic [26:0] mon_e;

    int m_buf[4];
    int m_ptr, m_fill, m_err;
    bit m_falla;

    typedef struct {
        logic [11:0] raw;
        int          exp_temp;
        logic        exp_listo;
        logic        exp_falla;
    } vec_t;
    vec_t vecs[19];

    acondicionador_temp #(
        .LOG2_N      (2),
        .OFFSET      (400),
        .MAX_ERR     (MAX_ERR),
        .TEMP_NEUTRA (220)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .muestra_valida (muestra_valida),
        .muestra_raw    (muestra_raw),
        .temp_entrada   (temp_entrada),
        .temp_valida    (temp_valida),
        .listo          (listo),
        .falla_sensor   (falla_sensor)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_buf[i] = 0;
        m_ptr   = 0;
        m_fill  = 0;
        m_err   = 0;
        m_falla = 0;
        exp_q.delete();
    endtask

    task automatic model_sample(input logic [11:0] raw);
        int c;
        int s;
        logic [15:0] cy;
        logic [10:0] t;
        if (m_falla) return;
        if (raw == 12'h000 || raw == 12'hFFF) begin
            if (m_err < MAX_ERR) m_err++;
            if (m_err == MAX_ERR) m_falla = 1;
        end else begin
            c = int'(raw) - 400;
            if (c > 1023) c = 1023;
            if (c < -1024) c = -1024;
            m_err = 0;
            m_buf[m_ptr] = c;
            m_ptr = (m_ptr + 1) % 4;
            if (m_fill < 4) m_fill++;
            if (m_fill == 4) begin
                s = m_buf[0] + m_buf[1] + m_buf[2] + m_buf[3];
                cy = 16'(cyc + 2);
                t  = 11'(s >>> 2);
                exp_q.push_back({cy, t});
            end
        end
    endtask

    task automatic send(input logic [11:0] raw);
        muestra_valida = 1'b1;
        muestra_raw    = raw;
        model_sample(raw);
        @(posedge clk);
        #1;
        muestra_valida = 1'b0;
    endtask

    task automatic idle(input int n);
        muestra_valida = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        muestra_valida = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Every pulse must match the head of the expected queue in both value and cycle.
    always @(negedge clk) begin
        if (temp_valida === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pulse: unexpected temp_valida at cycle %0d temp %0d", cyc, temp_entrada);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e[26:11] != 16'(cyc) || mon_e[10:0] != temp_entrada) begin
                    errors++;
                    $display("FAIL pulse: got temp %0d at cycle %0d expected temp %0d at cycle %0d",
                             temp_entrada, cyc, $signed(mon_e[10:0]), mon_e[26:11]);
                end
            end
        end
    end

    initial begin
        vecs[0]  = '{12'd620,  220,  1'b0, 1'b0};
        vecs[1]  = '{12'd620,  220,  1'b0, 1'b0};
        vecs[2]  = '{12'd620,  220,  1'b0, 1'b0};
        vecs[3]  = '{12'd620,  220,  1'b1, 1'b0};
        vecs[4]  = '{12'd1100, 340,  1'b1, 1'b0};
        vecs[5]  = '{12'd100,  210,  1'b1, 1'b0};
        vecs[6]  = '{12'd100,  80,   1'b1, 1'b0};
        vecs[7]  = '{12'd100,  -50,  1'b1, 1'b0};
        vecs[8]  = '{12'd99,   -301, 1'b1, 1'b0};
        vecs[9]  = '{12'd4000, 30,   1'b1, 1'b0};
        vecs[10] = '{12'd0,    30,   1'b1, 1'b0};
        vecs[11] = '{12'd620,  160,  1'b1, 1'b0};
        vecs[12] = '{12'hFFF,  160,  1'b1, 1'b0};
        vecs[13] = '{12'hFFF,  160,  1'b1, 1'b0};
        vecs[14] = '{12'd620,  290,  1'b1, 1'b0};
        vecs[15] = '{12'hFFF,  290,  1'b1, 1'b0};
        vecs[16] = '{12'hFFF,  290,  1'b1, 1'b0};
        vecs[17] = '{12'hFFF,  290,  1'b1, 1'b1};
        vecs[18] = '{12'd1100, 290,  1'b1, 1'b1};

        model_reset();
        rst = 1'b1;
        idle(2);
        do_reset();
        chk("reset temp_entrada", temp_entrada, 220);
        chk("reset temp_valida", temp_valida, 0);
        chk("reset listo", listo, 0);
        chk("reset falla_sensor", falla_sensor, 0);

        for (int i = 0; i < 19; i++) begin
            send(vecs[i].raw);
            idle(2);
            chk($sformatf("vec%0d temp_entrada", i), temp_entrada, vecs[i].exp_temp);
            chk($sformatf("vec%0d listo", i), listo, vecs[i].exp_listo);
            chk($sformatf("vec%0d falla_sensor", i), falla_sensor, vecs[i].exp_falla);
        end

        // Reset lands while the third fill sample is still in flight.
        do_reset();
        send(12'd900);
        send(12'd900);
        send(12'd900);
        do_reset();
        chk("midrst temp_entrada", temp_entrada, 220);
        chk("midrst temp_valida", temp_valida, 0);
        chk("midrst listo", listo, 0);
        chk("midrst falla_sensor", falla_sensor, 0);
        idle(1);
        chk("midrst no pulse after", temp_valida, 0);
        send(12'd900);
        send(12'd900);
        send(12'd900);
        idle(2);
        chk("refill 3 listo", listo, 0);
        chk("refill 3 temp_entrada", temp_entrada, 220);
        send(12'd900);
        idle(2);
        chk("refill 4 listo", listo, 1);
        chk("refill 4 temp_entrada", temp_entrada, 500);

        // Eight back-to-back strobes, each must yield its own pulse two cycles later.
        for (int i = 0; i < 8; i++) begin
            send(12'($urandom_range(1, 4094)));
        end
        idle(3);
        chk("b2b queue drained", exp_q.size(), 0);

        do_reset();
        for (int i = 0; i < 40; i++) begin
            int k;
            logic [11:0] r;
            k = $urandom_range(0, 9);
            if (k == 0) r = 12'h000;
            else if (k == 1) r = 12'hFFF;
            else r = 12'($urandom_range(1, 4094));
            if ($urandom_range(0, 3) != 0) send(r);
            else idle(1);
        end
        idle(4);
        chk("random falla_sensor", falla_sensor, int'(m_falla));
        chk("final queue empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
